// File: rtl/reg_file_rd.sv
// reg_file_rd: NREGS x WIDTH register file for the pipelined 10-bit CPU, with a
// per-register busy scoreboard and read-after-write hazard detection.
//
// Ports:
//   clk       - system clock, rising-edge active
//   reset     - asynchronous, active-high reset (clears registers and busy bits)
//   we        - writeback write enable
//   waddr     - writeback destination register
//   wdata     - writeback data
//   raddr_a   - read port A address        raddr_b - read port B address
//   use_a     - decode reads port A         use_b   - decode reads port B
//   rdata_a   - read port A data            rdata_b - read port B data
//   issue_en  - decode issues an instruction that writes issue_rd
//   issue_rd  - destination of the issued instruction
//   busy_a    - port A source has a pending producer
//   busy_b    - port B source has a pending producer
//   stall     - decode must hold: (use_a & busy_a) | (use_b & busy_b)
//
// Optional feature: define RF_BYPASS_EN for write-through forwarding. A write
// to the register being read is then visible on the read port in the same
// cycle and that port's busy flag is suppressed, so stall drops in the
// writeback cycle instead of one cycle later. Stored state is identical in
// both builds.

module reg_file_rd #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic             use_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             use_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  output logic             busy_a,
  output logic             busy_b,
  output logic             stall
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next-state for registers and scoreboard.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    busy_d = busy_q;
    if (we) begin
      regs_d[waddr] = wdata;
      busy_d[waddr] = 1'b0;
    end
    // Applied after the clear: a newer producer in flight keeps the register busy.
    if (issue_en) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Combinational read ports and hazard flags.
  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    busy_a  = busy_q[raddr_a];
    busy_b  = busy_q[raddr_b];
`ifdef RF_BYPASS_EN
    if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
      busy_a  = 1'b0;
    end
    if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
      busy_b  = 1'b0;
    end
`else
    // Without forwarding, the written value appears the cycle after writeback.
`endif
    stall = (use_a & busy_a) | (use_b & busy_b);
  end

  // Decode must never issue while stalled; issue_en is not gated here.
  issue_while_stalled_a: assert property (@(posedge clk) disable iff (reset)
                                          !(issue_en && stall));

endmodule

// File: tb/tb_reg_file_rd.sv
module tb_reg_file_rd;

  logic       clk;
  logic       reset;
  logic       we;
  logic [1:0] waddr;
  logic [9:0] wdata;
  logic [1:0] raddr_a;
  logic       use_a;
  logic [9:0] rdata_a;
  logic [1:0] raddr_b;
  logic       use_b;
  logic [9:0] rdata_b;
  logic       issue_en;
  logic [1:0] issue_rd;
  logic       busy_a;
  logic       busy_b;
  logic       stall;

  int total = 0;
  int bad   = 0;

  // Reference model: contents and outstanding-producer flags per register.
  logic [9:0] model_regs [4];
  logic       model_busy [4];

  reg_file_rd #(
    .WIDTH(10),
    .NREGS(4),
    .AW   (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .use_a   (use_a),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .use_b   (use_b),
    .rdata_b (rdata_b),
    .issue_en(issue_en),
    .issue_rd(issue_rd),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] exp_rd(input logic [1:0] a);
`ifdef RF_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return model_regs[a];
  endfunction

  function automatic logic exp_bs(input logic [1:0] a);
`ifdef RF_BYPASS_EN
    if (we && waddr == a) return 1'b0;
`endif
    return model_busy[a];
  endfunction

  function automatic logic exp_stall();
    return (use_a & exp_bs(raddr_a)) | (use_b & exp_bs(raddr_b));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      model_regs[i] = '0;
      model_busy[i] = 1'b0;
    end
  endtask

  // One clock edge: model takes the inputs held across the edge; returns at negedge.
  task automatic tick();
    logic       w_we, w_is;
    logic [1:0] w_wa, w_ir;
    logic [9:0] w_wd;
    w_we = we; w_wa = waddr; w_wd = wdata; w_is = issue_en; w_ir = issue_rd;
    @(posedge clk);
    if (w_we) begin
      model_regs[w_wa] = w_wd;
      model_busy[w_wa] = 1'b0;
    end
    if (w_is) model_busy[w_ir] = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
    use_a = 0; use_b = 0; issue_en = 0; issue_rd = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (rdata_a !== 10'd0 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_held: rdata_a=%h busy_a=%b required 000/0", rdata_a, busy_a);
    end
    @(negedge clk);
    reset = 1'b0;
    use_a = 1;
    for (int i = 0; i < 4; i++) begin
      raddr_a = 2'(i);
      #1;
      total++;
      if (rdata_a !== 10'd0) begin
        bad++;
        $display("FAIL reset_rdata[%0d]: got %h required 000", i, rdata_a);
      end
      total++;
      if (busy_a !== 1'b0) begin
        bad++;
        $display("FAIL reset_busy[%0d]: got %b required 0", i, busy_a);
      end
      total++;
      if (stall !== 1'b0) begin
        bad++;
        $display("FAIL reset_stall[%0d]: got %b required 0", i, stall);
      end
    end
    use_a = 0;
  endtask

  task automatic test_write_read();
    we = 1; waddr = 2; wdata = 10'b0001011111;
    tick();
    we = 0;
    raddr_a = 2;
    #1;
    total++;
    if (rdata_a !== 10'b0001011111) begin
      bad++;
      $display("FAIL write_read_r2: got %b required 0001011111", rdata_a);
    end
    we = 1; waddr = 3; wdata = 10'b1111010000;
    tick();
    we = 0;
    raddr_b = 3; raddr_a = 2;
    #1;
    total++;
    if (rdata_b !== 10'b1111010000) begin
      bad++;
      $display("FAIL write_read_r3: got %b required 1111010000", rdata_b);
    end
    total++;
    if (rdata_a !== 10'b0001011111) begin
      bad++;
      $display("FAIL write_read_r2_kept: got %b required 0001011111", rdata_a);
    end
  endtask

  task automatic test_hazard();
    issue_en = 1; issue_rd = 1;
    tick();
    issue_en = 0;
    raddr_a = 1; use_a = 1;
    #1;
    total++;
    if (busy_a !== 1'b1 || stall !== 1'b1) begin
      bad++;
      $display("FAIL hazard_stall: busy_a=%b stall=%b required 1/1", busy_a, stall);
    end
    use_a = 0;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL hazard_unused: stall=%b required 0", stall);
    end
    use_a = 1;
  endtask

  task automatic test_writeback_release();
    logic [9:0] old;
    old = model_regs[1];
    we = 1; waddr = 1; wdata = 10'b1100000011;
    #1;
`ifdef RF_BYPASS_EN
    total++;
    if (stall !== 1'b0 || rdata_a !== 10'b1100000011) begin
      bad++;
      $display("FAIL wb_same_cycle: stall=%b rdata_a=%b required 0/1100000011", stall, rdata_a);
    end
`else
    total++;
    if (stall !== 1'b1 || rdata_a !== old) begin
      bad++;
      $display("FAIL wb_same_cycle: stall=%b rdata_a=%b required 1/%b", stall, rdata_a, old);
    end
`endif
    tick();
    we = 0;
    #1;
    total++;
    if (stall !== 1'b0 || rdata_a !== 10'b1100000011) begin
      bad++;
      $display("FAIL wb_next_cycle: stall=%b rdata_a=%b required 0/1100000011", stall, rdata_a);
    end
    use_a = 0;
  endtask

  task automatic test_set_clear();
    use_a = 0; use_b = 0;
    issue_en = 1; issue_rd = 0;
    tick();
    we = 1; waddr = 0; wdata = 10'h2A5;
    issue_en = 1; issue_rd = 0;
    tick();
    we = 0; issue_en = 0;
    raddr_a = 0;
    #1;
    total++;
    if (busy_a !== 1'b1) begin
      bad++;
      $display("FAIL set_wins_busy: got %b required 1", busy_a);
    end
    total++;
    if (rdata_a !== 10'h2A5) begin
      bad++;
      $display("FAIL set_wins_data: got %h required 2a5", rdata_a);
    end
    // Retire the producer so later tests start from a clear scoreboard.
    we = 1; waddr = 0; wdata = 10'h2A5;
    tick();
    we = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom); waddr = 2'($urandom); wdata = 10'($urandom);
      raddr_a = 2'($urandom); raddr_b = 2'($urandom);
      use_a = 1'($urandom); use_b = 1'($urandom);
      issue_rd = 2'($urandom);
      issue_en = ($urandom_range(0, 2) == 0) && !exp_stall();
      #1;
      total++;
      if (rdata_a !== exp_rd(raddr_a) || rdata_b !== exp_rd(raddr_b)) begin
        bad++;
        $display("FAIL rand_rdata[%0d]: a=%h b=%h required %h %h", n, rdata_a, rdata_b,
                 exp_rd(raddr_a), exp_rd(raddr_b));
      end
      total++;
      if (busy_a !== exp_bs(raddr_a) || busy_b !== exp_bs(raddr_b)) begin
        bad++;
        $display("FAIL rand_busy[%0d]: a=%b b=%b required %b %b", n, busy_a, busy_b,
                 exp_bs(raddr_a), exp_bs(raddr_b));
      end
      total++;
      if (stall !== exp_stall()) begin
        bad++;
        $display("FAIL rand_stall[%0d]: got %b required %b", n, stall, exp_stall());
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    issue_en = 1; issue_rd = 1;
    we = 1; waddr = 2; wdata = 10'h15F;
    tick();
    idle_inputs();
    raddr_a = 2; raddr_b = 1;
    #1;
    total++;
    if (rdata_a !== 10'h15F || busy_b !== 1'b1) begin
      bad++;
      $display("FAIL async_setup: rdata_a=%h busy_b=%b required 15f/1", rdata_a, busy_b);
    end
    // Pulse reset strictly between clock edges.
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      raddr_a = 2'(i); raddr_b = 2'(3 - i);
      #1;
      total++;
      if (rdata_a !== 10'd0 || rdata_b !== 10'd0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
        bad++;
        $display("FAIL async_reset[%0d]: a=%h b=%h busy=%b%b required 000 000 00", i,
                 rdata_a, rdata_b, busy_a, busy_b);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    raddr_a = 2; raddr_b = 1;
    #1;
    total++;
    if (rdata_a !== 10'd0 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL async_after: rdata_a=%h busy_b=%b required 000/0", rdata_a, busy_b);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_hazard();
    test_writeback_release();
    test_set_clear();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
